dcache_dm: RTL and testbench
============================

DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 Parameter: S_OFFSET, default 5, byte-offset bits; line = 2^S_OFFSET bytes (256 b).
REQ-002 Parameter: S_INDEX, default 3, index bits; 2^S_INDEX sets, direct-mapped.
REQ-003 Tag width SHALL be 32-S_OFFSET-S_INDEX (24 at defaults).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 mem_address  in  32  byte address from pipeline MEM stage; bits [1:0] ignored.
REQ-007 mem_read  in  1  load request.
REQ-008 mem_write  in  1  store request.
REQ-009 mem_wdata  in  32  store data, already lane-shifted.
REQ-010 mem_byte_enable  in  4  per-byte store enable.
REQ-011 mem_rdata  out  32  aligned word read.
REQ-012 mem_resp  out  1  request complete, one-cycle pulse per request.
REQ-013 pmem_address  out  32  line-aligned memory address.
REQ-014 pmem_read  out  1  line-fill request.
REQ-015 pmem_write  out  1  line-writeback request.
REQ-016 pmem_wdata  out  256  victim line.
REQ-017 pmem_rdata  in  256  fill line.
REQ-018 pmem_resp  in  1  memory transfer complete, one-cycle pulse.

Function
REQ-019 Per set: valid bit, dirty bit, tag, 256-bit data line; write-back, write-allocate.
REQ-020 Address split: tag=[31:8], index=[7:5], word=[4:2] at defaults.
REQ-021 FSM states: CHECK, WRITEBACK, ALLOCATE; reset state CHECK.
REQ-022 CHECK, no request: all outputs 0 except mem_rdata (don't-care).
REQ-023 CHECK, hit (valid && tag match): mem_resp=1 combinationally same cycle; zero-wait hit latency.
REQ-024 Read hit: mem_rdata = line word [word*32 +: 32].
REQ-025 Write hit: at the clock edge, each byte i with mem_byte_enable[i]=1 merges mem_wdata byte i into word `word`; set dirty; other bytes unchanged.
REQ-026 Write with mem_byte_enable=0000 on hit: mem_resp=1, no data change, dirty still set.
REQ-027 mem_read && mem_write both high: treated as write.
REQ-028 CHECK, miss, victim clean or invalid: next state ALLOCATE.
REQ-029 CHECK, miss, victim valid && dirty: next state WRITEBACK.
REQ-030 WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line; stay until pmem_resp, then clear dirty, go ALLOCATE.
REQ-031 ALLOCATE: pmem_read=1, pmem_address={req tag, index, 5'b0}; on pmem_resp load line, set tag, valid=1, dirty=0, go CHECK.
REQ-032 After fill, the request completes in CHECK as a hit next cycle; miss latency = memory cycles + 1 (clean), + writeback cycles (dirty).
REQ-033 pmem_read and pmem_write SHALL never be high together; mem_resp SHALL be 0 in WRITEBACK and ALLOCATE.
REQ-034 Requestor holds address/control/data stable until mem_resp; cache behaviour on mid-miss change is undefined.
REQ-035 pmem_resp outside WRITEBACK/ALLOCATE SHALL be ignored.

Reset
REQ-036 rst=1 SHALL asynchronously clear all valid and dirty bits, force CHECK, drive mem_resp, pmem_read, pmem_write to 0.
REQ-037 rst mid-WRITEBACK or mid-ALLOCATE SHALL abort the transfer immediately; no array update from that transfer.
REQ-038 Tag and data arrays need not be reset.

Verification
REQ-039 Cold read 0x0000_0104 -> ALLOCATE, pmem_address=0x0000_0100; fill word1=0xDEADBEEF; next cycle mem_resp=1, mem_rdata=0xDEADBEEF.
REQ-040 Repeat read 0x0000_0104 -> mem_resp=1 same cycle, no pmem activity.
REQ-041 Store 0x0000_0106, wdata=0xAB000000... lane data 0x12340000, mbe=1100 -> resp same cycle; read 0x104 returns 0x1234BEEF.
REQ-042 Read 0x0001_0104 (same index, new tag) -> WRITEBACK to 0x0000_0100 with word1=0x1234BEEF, then ALLOCATE 0x0001_0100, then resp.
REQ-043 Assert rst during ALLOCATE -> pmem_read drops same cycle; subsequent read of same address misses again.
REQ-044 Read and write asserted together on hit to 0x104, mbe=1111, wdata=0x5 -> stored as write; later read returns 0x00000005.

Source files
------------

// File: rtl/dcache_dm.sv
// Direct-mapped write-back, write-allocate data cache between the pipeline MEM stage and a line-wide memory.
// Latency: hits complete combinationally in the request cycle; misses take fill cycles + 1, plus writeback cycles if the victim is dirty.
// Backpressure: mem_resp is held low until the request completes; the requestor keeps the request stable until then.
//
// Ports:
//   clk, rst                       sole clock (rising edge) and asynchronous active-high reset
//   mem_address/read/write/wdata   pipeline request; store data is already lane-shifted
//   mem_byte_enable                per-byte store enable
//   mem_rdata, mem_resp            aligned load word and one-cycle completion pulse
//   pmem_address/read/write/wdata  line-granular memory request (fill or victim writeback)
//   pmem_rdata, pmem_resp          fill line and one-cycle transfer-complete pulse
module dcache_dm #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [31:0]                 mem_address,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [31:0]                 mem_wdata,
    input  logic [3:0]                  mem_byte_enable,
    output logic [31:0]                 mem_rdata,
    output logic                        mem_resp,

    output logic [31:0]                 pmem_address,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [(8<<S_OFFSET)-1:0]    pmem_wdata,
    input  logic [(8<<S_OFFSET)-1:0]    pmem_rdata,
    input  logic                        pmem_resp
);

    localparam int S_TAG  = 32 - S_OFFSET - S_INDEX;
    localparam int SETS   = 1 << S_INDEX;
    localparam int LINE_W = 8 << S_OFFSET;
    localparam int S_WORD = S_OFFSET - 2;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Per-set bookkeeping. Only valid/dirty need reset; tag and data are
    // meaningless while valid is low.
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [S_TAG-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    // Request address fields.
    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] req_index;
    logic [S_WORD-1:0]  req_word;
    int                 word_base;

    assign req_tag   = mem_address[31 -: S_TAG];
    assign req_index = mem_address[S_OFFSET +: S_INDEX];
    assign req_word  = mem_address[2 +: S_WORD];
    assign word_base = 32 * int'(req_word);

    // Currently indexed set.
    logic [S_TAG-1:0]  cur_tag;
    logic [LINE_W-1:0] cur_line;
    logic              cur_valid;
    logic              cur_dirty;
    logic              hit;
    logic              request;

    assign cur_tag   = tag_q[req_index];
    assign cur_line  = data_q[req_index];
    assign cur_valid = valid_q[req_index];
    assign cur_dirty = dirty_q[req_index];
    assign hit       = cur_valid && (cur_tag == req_tag);
    assign request   = mem_read || mem_write;

    // Loads read straight out of the indexed line; the value is only
    // meaningful while mem_resp is high.
    assign mem_rdata = cur_line[word_base +: 32];

    // Store merge: only enabled byte lanes of the addressed word change.
    logic [LINE_W-1:0] merged_line;

    always_comb begin
        merged_line = cur_line;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                merged_line[word_base + b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    // Array update strobes produced by the FSM.
    logic hit_write_en;
    logic fill_en;
    logic wb_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CHECK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        hit_write_en = 1'b0;
        fill_en      = 1'b0;
        wb_done      = 1'b0;

        case (state_q)
            CHECK: begin
                if (request) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        // A simultaneous read+write is handled as a write.
                        hit_write_en = mem_write;
                    end else if (cur_valid && cur_dirty) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {cur_tag, req_index, {S_OFFSET{1'b0}}};
                pmem_wdata   = cur_line;
                if (pmem_resp) begin
                    wb_done = 1'b1;
                    state_d = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_index, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    fill_en = 1'b1;
                    // Back to CHECK, where the request completes as a hit.
                    state_d = CHECK;
                end
            end

            default: begin
                state_d = CHECK;
            end
        endcase
    end

    // Valid/dirty: reset clears every set, which also discards any dirty data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_en) begin
                valid_q[req_index] <= 1'b1;
                dirty_q[req_index] <= 1'b0;
            end else if (wb_done) begin
                dirty_q[req_index] <= 1'b0;
            end else if (hit_write_en) begin
                // Set even when no byte lane is enabled.
                dirty_q[req_index] <= 1'b1;
            end
        end
    end

    // Tag/data arrays. While rst is high the FSM sits in CHECK with every set
    // invalid, so neither strobe can fire and an aborted transfer never lands.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[req_index]  <= req_tag;
            data_q[req_index] <= pmem_rdata;
        end else if (hit_write_en) begin
            data_q[req_index] <= merged_line;
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: directed vector table, reset/idle corner cases, then randomized traffic against a line-level cache model.
// Latency: requests are issued one at a time and each is bounded by a cycle budget.
// Backpressure: a behavioural memory answers pmem requests after a random 0-3 cycle delay.
module tb_dcache_dm;

    logic         clk;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    dcache_dm #(.S_OFFSET(5), .S_INDEX(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int viol     = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Initial memory image; word 0x104 is pinned to a known value.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w*4));
        return l;
    endfunction

    // ---------------- behavioural memory responder ----------------
    logic [255:0] pm [bit [31:0]];
    bit  hold_mem = 1'b0;
    int  sp_req   = 0;

    initial begin
        int cnt;
        int sp_done;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        cnt        = 0;
        sp_done    = 0;
        forever begin
            @(negedge clk);
            if (rst || pmem_resp) begin
                pmem_resp = 1'b0;
                cnt = int'($urandom_range(0, 3));
            end else if (sp_req != sp_done) begin
                // Unsolicited pulse with garbage data.
                pmem_resp  = 1'b1;
                pmem_rdata = {8{32'hFFFF_FFFF}};
                sp_done    = sp_req;
            end else if ((pmem_read || pmem_write) && !hold_mem) begin
                if (cnt == 0) begin
                    if (pmem_write) begin
                        pm[pmem_address] = pmem_wdata;
                    end else begin
                        pmem_rdata = pm.exists(pmem_address) ? pm[pmem_address] : init_line(pmem_address);
                    end
                    pmem_resp = 1'b1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // ---------------- reference cache model ----------------
    bit           mvalid [8];
    bit           mdirty [8];
    logic [23:0]  mtag   [8];
    logic [255:0] mline  [8];
    logic [255:0] mmem   [bit [31:0]];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
    endtask

    task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] wd, input logic [3:0] be,
                                output bit hit, output bit wb, output logic [31:0] wb_a,
                                output logic [255:0] wb_l, output logic [31:0] rd);
        int idx;
        int w;
        logic [31:0] la;
        idx  = int'(a[7:5]);
        w    = int'(a[4:2]);
        hit  = mvalid[idx] && (mtag[idx] == a[31:8]);
        wb   = 1'b0;
        wb_a = '0;
        wb_l = '0;
        if (!hit) begin
            if (mvalid[idx] && mdirty[idx]) begin
                wb   = 1'b1;
                wb_a = {mtag[idx], a[7:5], 5'b0};
                wb_l = mline[idx];
                mmem[wb_a] = mline[idx];
            end
            la = {a[31:5], 5'b0};
            mline[idx]  = mmem.exists(la) ? mmem[la] : init_line(la);
            mtag[idx]   = a[31:8];
            mvalid[idx] = 1'b1;
            mdirty[idx] = 1'b0;
        end
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mline[idx][w*32 + b*8 +: 8] = wd[b*8 +: 8];
            mdirty[idx] = 1'b1;
        end
        rd = mline[idx][w*32 +: 32];
    endtask

    // ---------------- request driver / observer ----------------
    task automatic run_and_check(input string nm, input logic [31:0] a, input bit rd, input bit wr,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input bit exp_hit, input bit chk_rd, input logic [31:0] exp_rd,
                                 input bit exp_wb, input logic [31:0] exp_wb_a,
                                 input logic [255:0] exp_wb_l, input logic [255:0] wb_mask);
        int cyc, act, nwb, nfill;
        logic [31:0]  rdata, wb_a, fill_a;
        logic [255:0] wb_l;
        bit ok, pw, pr;
        @(posedge clk); #1;
        mem_address = a; mem_read = rd; mem_write = wr; mem_wdata = wd; mem_byte_enable = be;
        cyc = 0; act = 0; nwb = 0; nfill = 0; ok = 1'b0; pw = 1'b0; pr = 1'b0;
        rdata = '0; wb_a = '0; fill_a = '0; wb_l = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pmem_read && pmem_write) viol++;
            if (mem_resp && (pmem_read || pmem_write)) viol++;
            if (pmem_write && !pw) begin nwb++; wb_a = pmem_address; wb_l = pmem_wdata; end
            if (pmem_read && !pr) begin nfill++; fill_a = pmem_address; end
            pw = pmem_write;
            pr = pmem_read;
            if (pmem_read || pmem_write) act++;
            if (mem_resp) begin rdata = mem_rdata; ok = 1'b1; break; end
            cyc++;
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        check({nm, "_resp"}, 256'(ok), 256'(1'b1));
        check({nm, "_hit"}, 256'(cyc == 0), 256'(exp_hit));
        if (chk_rd) check({nm, "_rdata"}, 256'(rdata), 256'(exp_rd));
        check({nm, "_nwb"}, 256'(nwb), 256'(exp_wb));
        if (exp_wb && nwb == 1) begin
            check({nm, "_wb_addr"}, 256'(wb_a), 256'(exp_wb_a));
            check({nm, "_wb_data"}, wb_l & wb_mask, exp_wb_l & wb_mask);
        end
        check({nm, "_nfill"}, 256'(nfill), 256'(!exp_hit));
        if (!exp_hit && nfill == 1) begin
            check({nm, "_fill_addr"}, 256'(fill_a), 256'({a[31:5], 5'b0}));
            check({nm, "_latency"}, 256'(cyc), 256'(act + 1));
        end
    endtask

    // Run one request and compare against the model.
    task automatic model_req(input string nm, input logic [31:0] a, input bit rd, input bit wr,
                             input logic [31:0] wd, input logic [3:0] be);
        bit hit, wb;
        logic [31:0] wb_a, rdv;
        logic [255:0] wb_l;
        model_access(a, wr, wd, be, hit, wb, wb_a, wb_l, rdv);
        run_and_check(nm, a, rd, wr, wd, be, hit, rd && !wr, rdv, wb, wb_a, wb_l, {256{1'b1}});
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          rd;
        bit          wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          exp_hit;
        logic [31:0] exp_rdata;
        bit          exp_wb;
        logic [31:0] exp_wb_addr;
        logic [31:0] exp_wb_w1;
    } vec_t;

    vec_t        tbl [8];
    logic [23:0] tags [4];

    initial begin
        bit mh, mw;
        bit seen;
        logic [31:0] ma, mr;
        logic [255:0] ml, w1_mask, w1_line;
        logic [31:0] ra;

        rst = 1'b1;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_wdata = '0; mem_byte_enable = '0;
        model_reset();

        //                 addr          rd wr wdata          be       hit exp_rdata          wb  wb_addr        wb_word1
        tbl[0] = '{32'h0000_0104, 1, 0, 32'h0,          4'b0000, 0, 32'hDEAD_BEEF,      0, 32'h0,          32'h0};
        tbl[1] = '{32'h0000_0104, 1, 0, 32'h0,          4'b0000, 1, 32'hDEAD_BEEF,      0, 32'h0,          32'h0};
        tbl[2] = '{32'h0000_0106, 0, 1, 32'h1234_0000,  4'b1100, 1, 32'h0,              0, 32'h0,          32'h0};
        tbl[3] = '{32'h0000_0104, 1, 0, 32'h0,          4'b0000, 1, 32'h1234_BEEF,      0, 32'h0,          32'h0};
        tbl[4] = '{32'h0001_0104, 1, 0, 32'h0,          4'b0000, 0, init_word(32'h0001_0104), 1, 32'h0000_0100, 32'h1234_BEEF};
        tbl[5] = '{32'h0000_0104, 1, 0, 32'h0,          4'b0000, 0, 32'h1234_BEEF,      0, 32'h0,          32'h0};
        tbl[6] = '{32'h0000_0104, 1, 1, 32'h0000_0005,  4'b1111, 1, 32'h0,              0, 32'h0,          32'h0};
        tbl[7] = '{32'h0000_0104, 1, 0, 32'h0,          4'b0000, 1, 32'h0000_0005,      0, 32'h0,          32'h0};

        tags[0] = 24'h000000; tags[1] = 24'h000001; tags[2] = 24'h000123; tags[3] = 24'h800000;
        w1_mask = '0;
        w1_mask[63:32] = 32'hFFFF_FFFF;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_resp",   256'(mem_resp),   256'(1'b0));
        check("rst_pmem_read",  256'(pmem_read),  256'(1'b0));
        check("rst_pmem_write", 256'(pmem_write), 256'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle outputs.
        @(negedge clk);
        check("idle_mem_resp",   256'(mem_resp),     256'(1'b0));
        check("idle_pmem_rw",    256'({pmem_read, pmem_write}), 256'(2'b00));
        check("idle_pmem_addr",  256'(pmem_address), 256'(32'h0));
        check("idle_pmem_wdata", pmem_wdata,         256'(0));

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            w1_line = '0;
            w1_line[63:32] = tbl[i].exp_wb_w1;
            run_and_check($sformatf("vec%0d", i), tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdata, tbl[i].be,
                          tbl[i].exp_hit, tbl[i].rd && !tbl[i].wr, tbl[i].exp_rdata,
                          tbl[i].exp_wb, tbl[i].exp_wb_addr, w1_line, w1_mask);
            model_access(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].be, mh, mw, ma, ml, mr);
        end

        // Unsolicited pmem_resp while idle must not disturb the cache.
        sp_req++;
        repeat (3) @(posedge clk);
        model_req("spurious", 32'h0000_0104, 1'b1, 1'b0, 32'h0, 4'b0000);

        // Reset during ALLOCATE aborts the fill and discards all lines.
        hold_mem = 1'b1;
        @(posedge clk); #1;
        mem_address = 32'h2000_0040; mem_read = 1'b1; mem_write = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pmem_read) begin seen = 1'b1; break; end
        end
        check("rst_alloc_entered", 256'(seen), 256'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("rst_abort_pmem_read",  256'(pmem_read),  256'(1'b0));
        check("rst_abort_pmem_write", 256'(pmem_write), 256'(1'b0));
        check("rst_abort_mem_resp",   256'(mem_resp),   256'(1'b0));
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        hold_mem = 1'b0;
        model_reset();
        model_req("post_rst_read", 32'h2000_0040, 1'b1, 1'b0, 32'h0, 4'b0000);
        model_req("post_rst_lost", 32'h0000_0104, 1'b1, 1'b0, 32'h0, 4'b0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            int op;
            ra = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            op = int'($urandom_range(0, 9));
            model_req($sformatf("rnd%0d", n), ra, op < 5 || op == 9, op >= 5, $urandom, 4'($urandom_range(0, 15)));
        end

        check("pmem_rw_exclusive_and_resp_quiet", 256'(viol), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
